// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment scanner: refresh prescaler, scan index, hex decode,
// per-digit decimal points, leading-zero blanking and frame-synchronous (tear-free)
// value updates. Define SEVENSEG_DIM_EN to add a 4-bit PWM brightness control on
// the digit enables.
module sevenseg_scan_driver #(
  parameter int unsigned Digits       = 5,
  parameter int unsigned RefreshDiv   = 50000,
  parameter bit          SegActiveLow = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [4*Digits-1:0] digits_i,
  input  logic [Digits-1:0]   dp_i,
  input  logic                load_i,
  input  logic                lz_blank_i,
`ifdef SEVENSEG_DIM_EN
  input  logic [3:0]          brightness_i,
`endif
  output logic [Digits-1:0]   seg_sel_o,
  output logic [7:0]          seg_data_o,
  output logic                frame_done_o,
  output logic                pending_o
);

  localparam int unsigned PsW  = $clog2(RefreshDiv);
  localparam int unsigned IdxW = $clog2(Digits);
  localparam logic [PsW-1:0]  PsLast  = PsW'(RefreshDiv - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(Digits - 1);
  localparam logic [7:0]      SegOff  = SegActiveLow ? 8'hFF : 8'h00;

  logic [PsW-1:0]      ps_q, ps_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*Digits-1:0] pend_dig_q, pend_dig_d;
  logic [Digits-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_q, pend_d;
  logic [4*Digits-1:0] shd_dig_q, shd_dig_d;
  logic [Digits-1:0]   shd_dp_q, shd_dp_d;
  logic                frame_done_q, frame_done_d;
  logic [Digits-1:0]   seg_sel_q, seg_sel_d;
  logic [7:0]          seg_data_q, seg_data_d;

  logic                tick, boundary;
  logic [Digits-1:0]   blank;
  logic [Digits-1:0]   sel_onehot;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank;
  logic [6:0]          cur_seg;

  // Active-high segment pattern, bits g..a.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
    return seg;
  endfunction

  assign tick     = (ps_q == PsLast);
  assign boundary = tick && (idx_q == IdxLast);

  // Prescaler and scan index advance.
  always_comb begin
    ps_d  = tick ? '0 : ps_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  // Pending/shadow handoff; the shadow only changes on a frame boundary so a
  // frame never mixes old and new digits.
  always_comb begin
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_d     = pend_q;
    shd_dig_d  = shd_dig_q;
    shd_dp_d   = shd_dp_q;
    if (boundary && load_i) begin
      shd_dig_d = digits_i;
      shd_dp_d  = dp_i;
      pend_d    = 1'b0;
    end else if (boundary && pend_q) begin
      shd_dig_d = pend_dig_q;
      shd_dp_d  = pend_dp_q;
      pend_d    = 1'b0;
    end else if (load_i) begin
      pend_dig_d = digits_i;
      pend_dp_d  = dp_i;
      pend_d     = 1'b1;
    end
  end

  // Digit i is blankable when it and every more significant nibble are zero.
  always_comb begin
    logic hi_zero;
    hi_zero = 1'b1;
    blank   = '0;
    for (int i = Digits - 1; i >= 0; i--) begin
      hi_zero  = hi_zero & (shd_dig_q[4*i +: 4] == 4'h0);
      blank[i] = hi_zero && (i != 0);
    end
  end

  // Select the shadow digit addressed by the current scan index.
  always_comb begin
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    sel_onehot = '0;
    for (int unsigned i = 0; i < Digits; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib       = shd_dig_q[4*i +: 4];
        cur_dp        = shd_dp_q[i];
        cur_blank     = blank[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

`ifdef SEVENSEG_DIM_EN
  logic [3:0] pwm_q;

  // Free-running PWM phase for digit-enable dimming.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_q <= 4'h0;
    end else begin
      pwm_q <= pwm_q + 4'h1;
    end
  end

  // Digit enable gated by the brightness duty.
  always_comb begin
    seg_sel_d = (pwm_q <= brightness_i) ? sel_onehot : '0;
  end
`else
  // Digit enable follows the scan index directly.
  always_comb begin
    seg_sel_d = sel_onehot;
  end
`endif

  // Segment data with blanking; polarity inversion is the last step.
  always_comb begin
    cur_seg      = (lz_blank_i && cur_blank) ? 7'h00 : hex2seg(cur_nib);
    seg_data_d   = {cur_dp, cur_seg} ^ {8{SegActiveLow}};
    frame_done_d = boundary;
  end

  // All state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ps_q         <= '0;
      idx_q        <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_q       <= 1'b0;
      shd_dig_q    <= '0;
      shd_dp_q     <= '0;
      frame_done_q <= 1'b0;
      seg_sel_q    <= '0;
      seg_data_q   <= SegOff;
    end else begin
      ps_q         <= ps_d;
      idx_q        <= idx_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_q       <= pend_d;
      shd_dig_q    <= shd_dig_d;
      shd_dp_q     <= shd_dp_d;
      frame_done_q <= frame_done_d;
      seg_sel_q    <= seg_sel_d;
      seg_data_q   <= seg_data_d;
    end
  end

  assign seg_sel_o    = seg_sel_q;
  assign seg_data_o   = seg_data_q;
  assign frame_done_o = frame_done_q;
  assign pending_o    = pend_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver (5 digits, 4 clk per slot). Expected
// slot contents are pushed per frame; a monitor pops one entry per new digit slot.
module tb_sevenseg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [19:0] digits;
  logic [4:0]  dp;
  logic        load;
  logic        lz;
  logic [4:0]  seg_sel_o, al_sel;
  logic [7:0]  seg_data_o, al_data;
  logic        frame_done_o, al_fd;
  logic        pending_o, al_pend;
`ifdef SEVENSEG_DIM_EN
  logic [3:0]  brightness;
`endif

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  bit mon_en = 1'b1;
  logic [12:0] exp_q[$];

  sevenseg_scan_driver #(.Digits(5), .RefreshDiv(4), .SegActiveLow(1'b0)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .digits_i    (digits),
    .dp_i        (dp),
    .load_i      (load),
    .lz_blank_i  (lz),
`ifdef SEVENSEG_DIM_EN
    .brightness_i(brightness),
`endif
    .seg_sel_o   (seg_sel_o),
    .seg_data_o  (seg_data_o),
    .frame_done_o(frame_done_o),
    .pending_o   (pending_o)
  );

  sevenseg_scan_driver #(.Digits(5), .RefreshDiv(4), .SegActiveLow(1'b1)) u_dut_al (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .digits_i    (digits),
    .dp_i        (dp),
    .load_i      (load),
    .lz_blank_i  (lz),
`ifdef SEVENSEG_DIM_EN
    .brightness_i(brightness),
`endif
    .seg_sel_o   (al_sel),
    .seg_data_o  (al_data),
    .frame_done_o(al_fd),
    .pending_o   (al_pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // f holds digit4..digit0 from MSB to LSB, one byte per digit.
  task automatic push_frame(input logic [39:0] f);
    for (int i = 0; i < 5; i++) begin
      logic [4:0] s;
      s = 5'b00001 << i;
      exp_q.push_back({s, f[8*i +: 8]});
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done_o && n < 40);
    chk("frame_done", frame_done_o, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " seg_sel"}, seg_sel_o, 0);
    chk({tag, " seg_data"}, seg_data_o, 8'h00);
    chk({tag, " frame_done"}, frame_done_o, 0);
    chk({tag, " pending"}, pending_o, 0);
    chk({tag, " seg_data active-low"}, al_data, 8'hFF);
  endtask

  // Slot monitor: each time a new digit enable appears, compare against the queue.
  initial begin
    logic [4:0] last_sel;
    last_sel = '0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && seg_sel_o != 5'b0 && seg_sel_o != last_sel) begin
        if (exp_q.size() == 0) begin
          chk("queue underrun", exp_q.size(), 1);
        end else begin
          logic [12:0] e;
          logic [7:0]  inv;
          e   = exp_q.pop_front();
          inv = ~e[7:0];
          chk("slot seg_sel", seg_sel_o, e[12:8]);
          chk("slot seg_data", seg_data_o, e[7:0]);
          chk("slot seg_sel active-low", al_sel, e[12:8]);
          chk("slot seg_data active-low", al_data, inv);
        end
      end
      last_sel = seg_sel_o;
    end
  end

  // Frame period monitor: frame_done pulses every 5 digits * 4 clk.
  initial begin
    int last;
    last = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last = -1;
      end else if (frame_done_o) begin
        if (last >= 0) chk("frame period", cyc - last, 20);
        last = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    digits = '0;
    dp     = '0;
    load   = 1'b0;
    lz     = 1'b0;
`ifdef SEVENSEG_DIM_EN
    brightness = 4'hF;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Frame A: empty shadow, no blanking.
    push_frame({8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F});
    rst_n = 1'b1;
    wait_frame();

    // Frame B: load 0x12345 while idx=2; B must still show the old value.
    push_frame({8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F});
    repeat (9) @(negedge clk);
    chk("sel at load", seg_sel_o, 5'b00100);
    digits = 20'h12345;
    dp     = 5'b00000;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("pending after load", pending_o, 1);
    push_frame({8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D});
    wait_frame();
    chk("pending cleared", pending_o, 0);

    // Frame C: two loads, last one wins.
    repeat (2) @(negedge clk);
    digits = 20'h99999;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    digits = 20'h0ABCD;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push_frame({8'h3F, 8'h77, 8'h7C, 8'h39, 8'h5E});
    wait_frame();

    // Frame D: load in the boundary tick; E shows it directly, pending stays low.
    repeat (19) @(negedge clk);
    chk("pending before sim load", pending_o, 0);
    digits = 20'h00042;
    dp     = 5'b00100;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("frame_done at sim load", frame_done_o, 1);
    chk("pending at sim load", pending_o, 0);
    push_frame({8'h3F, 8'h3F, 8'hBF, 8'h66, 8'h5B});
    wait_frame();
    chk("pending after sim frame", pending_o, 0);

    // Frame F/G: leading-zero blanking, dp survives blanking.
    lz = 1'b1;
    push_frame({8'h00, 8'h00, 8'h80, 8'h66, 8'h5B});
    wait_frame();
    push_frame({8'h00, 8'h00, 8'h80, 8'h66, 8'h5B});
    repeat (5) @(negedge clk);
    digits = 20'h00000;
    dp     = 5'b00000;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push_frame({8'h00, 8'h00, 8'h00, 8'h00, 8'h3F});
    wait_frame();

    // Frame H: all-zero value, digit 0 stays lit; then reset mid-frame with a load pending.
    repeat (6) @(negedge clk);
    digits = 20'h77777;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("pending before reset", pending_o, 1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs("mid-frame reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Pending 0x77777 is lost: the shadow is zero again.
    push_frame({8'h00, 8'h00, 8'h00, 8'h00, 8'h3F});
    rst_n = 1'b1;
    wait_frame();
    mon_en = 1'b0;
    chk("pending after reset frame", pending_o, 0);
    chk("queue drained", exp_q.size(), 0);

`ifdef SEVENSEG_DIM_EN
    begin
      int on_cnt;
      brightness = 4'h3;
      repeat (2) @(negedge clk);
      on_cnt = 0;
      repeat (32) begin
        @(negedge clk);
        if (seg_sel_o != 5'b0) on_cnt++;
      end
      chk("dim duty", on_cnt, 8);
      brightness = 4'hF;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
